pcie_dma_mwr_req_arb: RTL and testbench



---
 rtl/pcie_dma_mwr_arb_pkg.sv | 18 +
 rtl/pcie_dma_rr_pick.sv | 25 ++
 rtl/pcie_dma_mwr_req_arb.sv | 168 ++++++++++++++++
 tb/tb_pcie_dma_mwr_req_arb.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pcie_dma_mwr_arb_pkg.sv
// rtl/pcie_dma_mwr_arb_pkg.sv - shared widths and FSM encoding for the MWr request arbiter
package pcie_dma_mwr_arb_pkg;

    localparam int LEN_W  = 10;
    localparam int ADDR_W = 64;
    localparam int DATA_W = 32;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE,
        ST_ISSUE = ISSUE,
        ST_RUN   = RUN
    } arb_state_e;

endpackage

// File: rtl/pcie_dma_rr_pick.sv
// rtl/pcie_dma_rr_pick.sv - combinational round-robin picker, lowest index at or after ptr
module pcie_dma_rr_pick #(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [IDX_W-1:0]  ptr_i,
    output logic [NUM_CH-1:0] grant_o,
    output logic [IDX_W-1:0]  idx_o,
    output logic              valid_o
);

    // Walk offsets from farthest to nearest so the nearest requester overwrites last.
    always_comb begin
        idx_o = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req_i[(int'(ptr_i) + i) % NUM_CH]) begin
                idx_o = IDX_W'((int'(ptr_i) + i) % NUM_CH);
            end
        end
        valid_o = |req_i;
        grant_o = valid_o ? (NUM_CH'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/pcie_dma_mwr_req_arb.sv
// rtl/pcie_dma_mwr_req_arb.sv - round-robin sequencer sharing the MWr TX engine among DMA channels
module pcie_dma_mwr_req_arb
    import pcie_dma_mwr_arb_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int TMO_CYC = 4095
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        i_ch_req,
    input  logic [NUM_CH-1:0]        i_ch_is64,
    input  logic [NUM_CH-1:0]        i_ch_udf,
    input  logic [NUM_CH*LEN_W-1:0]  i_ch_len,
    input  logic [NUM_CH*ADDR_W-1:0] i_ch_addr,
    input  logic [NUM_CH*DATA_W-1:0] i_ch_data,
    output logic [NUM_CH-1:0]        o_ch_ack,
    output logic [NUM_CH-1:0]        o_ch_done,
    output logic [NUM_CH-1:0]        o_ch_err,
    output logic                     o_mwr32_req,
    output logic                     o_mwr64_req,
    input  logic                     i_mwr32_req_ack,
    input  logic                     i_mwr64_req_ack,
    output logic [LEN_W-1:0]         o_req_length,
    output logic [ADDR_W-1:0]        o_req_addr,
    output logic [DATA_W-1:0]        o_req_data,
    output logic                     o_user_define_data_flag,
    input  logic                     i_mwr_tx_busy,
    output logic                     o_arb_busy
);

    localparam int IDX_W = $clog2(NUM_CH);

    arb_state_e          state_q, state_d;
    logic [IDX_W-1:0]    rr_q, rr_d, g_q, g_d;
    logic                is64_q, is64_d, udf_q, udf_d, seen_q, seen_d;
    logic                m32_q, m32_d, m64_q, m64_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [NUM_CH-1:0]   ack_q, ack_d, done_q, done_d, err_q, err_d;
    logic [15:0]         wdog_q, wdog_d;
    logic [NUM_CH-1:0]   pick_grant, g_onehot;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_valid, eng_ack;

    pcie_dma_rr_pick #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_pick (
        .req_i   (i_ch_req),
        .ptr_i   (rr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    assign g_onehot = NUM_CH'(1) << g_q;
    // Only the ack matching the latched width counts; the other one is ignored.
    assign eng_ack  = is64_q ? i_mwr64_req_ack : i_mwr32_req_ack;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        g_d     = g_q;
        is64_d  = is64_q;
        udf_d   = udf_q;
        len_d   = len_q;
        addr_d  = addr_q;
        data_d  = data_q;
        m32_d   = m32_q;
        m64_d   = m64_q;
        seen_d  = seen_q;
        wdog_d  = wdog_q;
        ack_d   = '0;
        done_d  = '0;
        err_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    g_d     = pick_idx;
                    rr_d    = (pick_idx == IDX_W'(NUM_CH - 1)) ? '0 : pick_idx + 1'b1;
                    is64_d  = i_ch_is64[pick_idx];
                    udf_d   = i_ch_udf[pick_idx];
                    len_d   = i_ch_len[pick_idx*LEN_W +: LEN_W];
                    addr_d  = i_ch_addr[pick_idx*ADDR_W +: ADDR_W];
                    data_d  = i_ch_data[pick_idx*DATA_W +: DATA_W];
                    m64_d   = i_ch_is64[pick_idx];
                    m32_d   = !i_ch_is64[pick_idx];
                    ack_d   = pick_grant;
                    wdog_d  = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                wdog_d = wdog_q + 16'd1;
                if (eng_ack) begin
                    m32_d   = 1'b0;
                    m64_d   = 1'b0;
                    seen_d  = 1'b0;
                    state_d = ST_RUN;
                end else if (wdog_d == 16'(TMO_CYC)) begin
                    m32_d   = 1'b0;
                    m64_d   = 1'b0;
                    err_d   = g_onehot;
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Busy may still be low on RUN entry; completion needs a high-then-low.
                wdog_d = wdog_q + 16'd1;
                seen_d = seen_q | i_mwr_tx_busy;
                if (seen_q && !i_mwr_tx_busy) begin
                    done_d  = g_onehot;
                    state_d = ST_IDLE;
                end else if (wdog_d == 16'(TMO_CYC)) begin
                    err_d   = g_onehot;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rr_q    <= '0;
            g_q     <= '0;
            is64_q  <= 1'b0;
            udf_q   <= 1'b0;
            len_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            m32_q   <= 1'b0;
            m64_q   <= 1'b0;
            seen_q  <= 1'b0;
            wdog_q  <= '0;
            ack_q   <= '0;
            done_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            g_q     <= g_d;
            is64_q  <= is64_d;
            udf_q   <= udf_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            m32_q   <= m32_d;
            m64_q   <= m64_d;
            seen_q  <= seen_d;
            wdog_q  <= wdog_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign o_ch_ack                = ack_q;
    assign o_ch_done               = done_q;
    assign o_ch_err                = err_q;
    assign o_mwr32_req             = m32_q;
    assign o_mwr64_req             = m64_q;
    assign o_req_length            = len_q;
    assign o_req_addr              = addr_q;
    assign o_req_data              = data_q;
    assign o_user_define_data_flag = udf_q;
    assign o_arb_busy              = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pcie_dma_mwr_req_arb.sv
// tb/tb_pcie_dma_mwr_req_arb.sv - directed bench for the MWr request arbiter with an engine model
module tb_pcie_dma_mwr_req_arb;

    localparam int NCH = 4;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NCH-1:0]    ch_req = '0, ch_is64 = '0, ch_udf = '0;
    logic [NCH*10-1:0] ch_len = '0;
    logic [NCH*64-1:0] ch_addr = '0;
    logic [NCH*32-1:0] ch_data = '0;
    logic              ack32 = 1'b0, ack64 = 1'b0, busy = 1'b0;
    logic [NCH-1:0]    o_ch_ack, o_ch_done, o_ch_err;
    logic              o_mwr32_req, o_mwr64_req, o_user_define_data_flag, o_arb_busy;
    logic [9:0]        o_req_length;
    logic [63:0]       o_req_addr;
    logic [31:0]       o_req_data;

    pcie_dma_mwr_req_arb #(.NUM_CH(NCH), .TMO_CYC(TMO)) dut (
        .clk(clk), .rst(rst),
        .i_ch_req(ch_req), .i_ch_is64(ch_is64), .i_ch_udf(ch_udf),
        .i_ch_len(ch_len), .i_ch_addr(ch_addr), .i_ch_data(ch_data),
        .o_ch_ack(o_ch_ack), .o_ch_done(o_ch_done), .o_ch_err(o_ch_err),
        .o_mwr32_req(o_mwr32_req), .o_mwr64_req(o_mwr64_req),
        .i_mwr32_req_ack(ack32), .i_mwr64_req_ack(ack64),
        .o_req_length(o_req_length), .o_req_addr(o_req_addr), .o_req_data(o_req_data),
        .o_user_define_data_flag(o_user_define_data_flag),
        .i_mwr_tx_busy(busy), .o_arb_busy(o_arb_busy)
    );

    int checks = 0, errors = 0, cyc = 0;
    int ack_cnt[NCH], done_cnt[NCH], err_cnt[NCH], req_left[NCH], ack_cyc[NCH];
    int last_done_cyc, last_err_cyc, busy_fall_cyc, overlap, m32_cycles, hs_cycles;
    int order[$];
    int e_st = 0, e_cnt = 0, e_bcnt = 0, ack_dly = 1, busy_len = 3;

    // One cycle: engine model reacts first, then outputs are recorded and requesters drop on ack.
    task automatic step();
        @(negedge clk);
        cyc++;
        case (e_st)
            0: if ((o_mwr32_req || o_mwr64_req) && ack_dly >= 0) begin
                if (e_cnt == ack_dly) begin
                    ack32 = o_mwr32_req; ack64 = o_mwr64_req; e_st = 1;
                end else e_cnt++;
            end
            1: if (!o_mwr32_req && !o_mwr64_req) begin
                ack32 = 1'b0; ack64 = 1'b0; busy = 1'b1; e_bcnt = busy_len; e_st = 2;
            end
            default: begin
                e_bcnt--;
                if (e_bcnt == 0) begin
                    busy = 1'b0; e_st = 0; e_cnt = 0; busy_fall_cyc = cyc;
                end
            end
        endcase
        for (int c = 0; c < NCH; c++) begin
            if (o_ch_ack[c]) begin
                ack_cnt[c]++; ack_cyc[c] = cyc; order.push_back(c);
                if (req_left[c] > 0) req_left[c]--;
                if (req_left[c] == 0) ch_req[c] = 1'b0;
            end
            if (o_ch_done[c]) begin done_cnt[c]++; last_done_cyc = cyc; end
            if (o_ch_err[c]) begin err_cnt[c]++; last_err_cyc = cyc; end
        end
        if (o_mwr32_req && o_mwr64_req) overlap++;
        if (o_mwr32_req) m32_cycles++;
        if ((o_mwr32_req && ack32) || (o_mwr64_req && ack64)) hs_cycles++;
    endtask

    task automatic clear_stats();
        for (int c = 0; c < NCH; c++) begin
            ack_cnt[c] = 0; done_cnt[c] = 0; err_cnt[c] = 0; ack_cyc[c] = 0;
        end
        order.delete();
        overlap = 0; m32_cycles = 0; hs_cycles = 0; last_done_cyc = 0; last_err_cyc = 0;
    endtask

    task automatic set_ch(input int c, input logic is64, input logic udf, input logic [9:0] len,
                          input logic [63:0] addr, input logic [31:0] data, input int n);
        ch_is64[c] = is64; ch_udf[c] = udf;
        ch_len[c*10 +: 10] = len; ch_addr[c*64 +: 64] = addr; ch_data[c*32 +: 32] = data;
        req_left[c] = n; ch_req[c] = 1'b1;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        do begin step(); n++; end while ((o_arb_busy || (|ch_req)) && n < budget);
        checks++;
        if (n >= budget) begin errors++; $display("FAIL wait_idle budget %0d cycles expired", budget); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        checks++; if ({o_ch_ack, o_ch_done, o_ch_err} !== 12'h0) begin errors++; $display("FAIL reset_pulses got %0h exp 0", {o_ch_ack, o_ch_done, o_ch_err}); end
        checks++; if ({o_mwr32_req, o_mwr64_req, o_arb_busy} !== 3'b0) begin errors++; $display("FAIL reset_req got %0b exp 000", {o_mwr32_req, o_mwr64_req, o_arb_busy}); end
        checks++; if ({o_req_length, o_req_addr, o_req_data, o_user_define_data_flag} !== '0) begin errors++; $display("FAIL reset_fields got nonzero exp 0"); end
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        int exp_order[12] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
        clear_stats(); ack_dly = 1; busy_len = 3;
        for (int c = 0; c < NCH; c++) set_ch(c, c[0], 1'b0, 10'(c + 1), 64'h100 * c, 32'(c), 3);
        wait_idle(400);
        checks++; if (order.size() != 12) begin errors++; $display("FAIL rr_grants got %0d exp 12", order.size()); end
        for (int i = 0; i < 12; i++) begin
            checks++; if (order[i] != exp_order[i]) begin errors++; $display("FAIL rr_order[%0d] got %0d exp %0d", i, order[i], exp_order[i]); end
        end
        for (int c = 0; c < NCH; c++) begin
            checks++; if (done_cnt[c] != 3) begin errors++; $display("FAIL rr_done[%0d] got %0d exp 3", c, done_cnt[c]); end
        end
        checks++; if (overlap != 0) begin errors++; $display("FAIL rr_overlap got %0d exp 0", overlap); end
    endtask

    task automatic test_single_mwr32();
        int req_cyc;
        clear_stats(); ack_dly = 1; busy_len = 12;
        req_cyc = cyc;
        set_ch(1, 1'b0, 1'b0, 10'h020, 64'h0000_0000_1000_0040, 32'h1234_5678, 1);
        wait_idle(100);
        checks++; if (ack_cnt[1] != 1) begin errors++; $display("FAIL s32_ack_cnt got %0d exp 1", ack_cnt[1]); end
        checks++; if (ack_cyc[1] != req_cyc + 1) begin errors++; $display("FAIL s32_ack_lat got %0d exp %0d", ack_cyc[1] - req_cyc, 1); end
        checks++; if (m32_cycles != 2) begin errors++; $display("FAIL s32_req_cycles got %0d exp 2", m32_cycles); end
        checks++; if (hs_cycles != 1) begin errors++; $display("FAIL s32_handshake got %0d exp 1", hs_cycles); end
        checks++; if (o_req_addr !== 64'h1000_0040) begin errors++; $display("FAIL s32_addr got %0h exp 10000040", o_req_addr); end
        checks++; if (o_req_length !== 10'h020) begin errors++; $display("FAIL s32_len got %0h exp 20", o_req_length); end
        checks++; if (done_cnt[1] != 1) begin errors++; $display("FAIL s32_done_cnt got %0d exp 1", done_cnt[1]); end
        checks++; if (last_done_cyc != busy_fall_cyc + 1) begin errors++; $display("FAIL s32_done_timing got %0d exp %0d", last_done_cyc, busy_fall_cyc + 1); end
        checks++; if (last_done_cyc - ack_cyc[1] != 15) begin errors++; $display("FAIL s32_total got %0d exp 15", last_done_cyc - ack_cyc[1]); end
    endtask

    task automatic test_mwr64_udf();
        clear_stats(); ack_dly = 1; busy_len = 2;
        set_ch(2, 1'b1, 1'b1, 10'h001, 64'h0000_0012_3456_7800, 32'hDEAD_BEEF, 1);
        step();
        checks++; if ({o_mwr64_req, o_mwr32_req} !== 2'b10) begin errors++; $display("FAIL m64_req got %0b exp 10", {o_mwr64_req, o_mwr32_req}); end
        checks++; if (o_user_define_data_flag !== 1'b1) begin errors++; $display("FAIL m64_udf got %0b exp 1", o_user_define_data_flag); end
        checks++; if (o_req_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL m64_data got %0h exp deadbeef", o_req_data); end
        checks++; if (o_req_addr !== 64'h0000_0012_3456_7800) begin errors++; $display("FAIL m64_addr got %0h exp 1234567800", o_req_addr); end
        wait_idle(100);
        checks++; if (done_cnt[2] != 1 || m32_cycles != 0) begin errors++; $display("FAIL m64_done got %0d/%0d exp 1/0", done_cnt[2], m32_cycles); end
    endtask

    task automatic test_timeout();
        int n = 0;
        clear_stats(); ack_dly = -1; busy_len = 3;
        set_ch(3, 1'b0, 1'b0, 10'h004, 64'h3000, 32'h3, 1);
        set_ch(0, 1'b1, 1'b0, 10'h008, 64'h4000, 32'h4, 1);
        while (err_cnt[3] == 0 && n < 100) begin step(); n++; end
        checks++; if (err_cnt[3] != 1) begin errors++; $display("FAIL tmo_err got %0d exp 1", err_cnt[3]); end
        checks++; if (last_err_cyc - ack_cyc[3] != 16) begin errors++; $display("FAIL tmo_delay got %0d exp 16", last_err_cyc - ack_cyc[3]); end
        checks++; if ({o_mwr32_req, o_mwr64_req} !== 2'b00) begin errors++; $display("FAIL tmo_req_drop got %0b exp 00", {o_mwr32_req, o_mwr64_req}); end
        ack_dly = 1;
        wait_idle(100);
        checks++; if (done_cnt[3] != 0) begin errors++; $display("FAIL tmo_no_done got %0d exp 0", done_cnt[3]); end
        checks++; if (order.size() != 2 || order[0] != 3 || order[1] != 0) begin errors++; $display("FAIL tmo_next_grant got size %0d first %0d exp 3 then 0", order.size(), order[0]); end
        checks++; if (done_cnt[0] != 1 || err_cnt[0] != 0) begin errors++; $display("FAIL tmo_ch0 got done %0d err %0d exp 1 0", done_cnt[0], err_cnt[0]); end
    endtask

    task automatic test_len0();
        clear_stats(); ack_dly = 1; busy_len = 11;
        set_ch(1, 1'b1, 1'b0, 10'h000, 64'h8000, 32'h5, 1);
        step();
        checks++; if (o_req_length !== 10'h000) begin errors++; $display("FAIL len0_len got %0h exp 0", o_req_length); end
        wait_idle(100);
        checks++; if (done_cnt[1] != 1 || err_cnt[1] != 0) begin errors++; $display("FAIL len0_done got %0d err %0d exp 1 0", done_cnt[1], err_cnt[1]); end
        checks++; if (last_done_cyc != busy_fall_cyc + 1) begin errors++; $display("FAIL len0_timing got %0d exp %0d", last_done_cyc, busy_fall_cyc + 1); end
        checks++; if (last_done_cyc - ack_cyc[1] != 14) begin errors++; $display("FAIL len0_total got %0d exp 14", last_done_cyc - ack_cyc[1]); end
    endtask

    task automatic test_reset_in_run();
        int n = 0;
        clear_stats(); ack_dly = 1; busy_len = 20;
        set_ch(1, 1'b0, 1'b1, 10'h010, 64'h9000, 32'h6, 1);
        while (e_st != 2 && n < 20) begin step(); n++; end
        step(); step();
        rst = 1'b1;
        #1;
        checks++; if ({o_arb_busy, o_mwr32_req, o_mwr64_req, o_user_define_data_flag} !== 4'b0) begin errors++; $display("FAIL rstrun_ctrl got %0b exp 0000", {o_arb_busy, o_mwr32_req, o_mwr64_req, o_user_define_data_flag}); end
        checks++; if ({o_req_addr, o_req_length, o_req_data} !== '0) begin errors++; $display("FAIL rstrun_fields got %0h exp 0", o_req_addr); end
        ack32 = 1'b0; ack64 = 1'b0; busy = 1'b0; e_st = 0; e_cnt = 0;
        repeat (3) step();
        rst = 1'b0;
        busy_len = 3;
        set_ch(3, 1'b0, 1'b0, 10'h002, 64'hA000, 32'h7, 1);
        set_ch(1, 1'b0, 1'b0, 10'h002, 64'hB000, 32'h8, 1);
        wait_idle(100);
        checks++; if (done_cnt[1] != 1 || err_cnt[1] != 0) begin errors++; $display("FAIL rstrun_no_pulse got done %0d err %0d exp 1 0", done_cnt[1], err_cnt[1]); end
        checks++; if (order.size() != 3 || order[1] != 1 || order[2] != 3) begin errors++; $display("FAIL rstrun_ptr got size %0d second %0d exp 1 then 3", order.size(), order[1]); end
        checks++; if (ack_cnt[3] != 1 || done_cnt[3] != 1) begin errors++; $display("FAIL rstrun_ch3 got ack %0d done %0d exp 1 1", ack_cnt[3], done_cnt[3]); end
    endtask

    initial begin
        for (int c = 0; c < NCH; c++) req_left[c] = 0;
        clear_stats();
        test_reset();
        test_round_robin();
        test_single_mwr32();
        test_mwr64_udf();
        test_timeout();
        test_len0();
        test_reset_in_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout reached at cycle %0d", cyc);
        $fatal(1, "global timeout");
    end

endmodule
